// File: rtl/uart_tx_packetizer.sv
// uart_tx_packetizer: buffers 32-bit words and frames them as SYNC + little-endian payload (+ XOR byte if UART_TX_PKT_CHECKSUM_EN).
// SYNC is offered two cycles after the first word is written; tx_ready stalls the frame, a full FIFO drops in_ready.
module uart_tx_packetizer #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             in_data,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    busy,
  output logic                    pkt_done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

`ifdef UART_TX_PKT_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, CSUM} state_t;
  logic [7:0] csum;
`else
  typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD} state_t;
`endif

  state_t        state, state_nxt;
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    byte_idx;
  logic [32:0]   head;
  logic          push, pop, hs, done_hs;

  assign head     = mem[rd_ptr];
  assign in_ready = (fifo_count != FULL);
  assign push     = in_valid && in_ready;
  assign hs       = tx_valid && tx_ready;
  assign busy     = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs depend only on state, byte_idx, csum and the FIFO head, never on tx_ready.
  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    pop       = 1'b0;
    done_hs   = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) state_nxt = SYNC;
      end
      SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        tx_valid = (fifo_count != '0);
        tx_data  = head[{byte_idx, 3'b000} +: 8];
        if (tx_valid && tx_ready && byte_idx == 2'd3) begin
          pop = 1'b1;
          if (head[32]) begin
`ifdef UART_TX_PKT_CHECKSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = IDLE;
            done_hs   = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_PKT_CHECKSUM_EN
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (tx_ready) begin
          state_nxt = IDLE;
          done_hs   = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= done_hs;
      if (hs && state == SYNC)         byte_idx <= '0;
      else if (hs && state == PAYLOAD) byte_idx <= byte_idx + 1'b1;
    end
  end

`ifdef UART_TX_PKT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                      csum <= '0;
    else if (hs && state == SYNC)    csum <= '0;
    else if (hs && state == PAYLOAD) csum <= csum ^ tx_data;
  end
`endif

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Scoreboard bench for uart_tx_packetizer: model bytes are queued as words are accepted and popped on each byte handshake.
module tb_uart_tx_packetizer;
  localparam int DEPTH = 16;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_TX_PKT_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  typedef struct {
    logic [7:0] b;
    bit         fin;
  } item_t;

  logic        clk, rst_n;
  logic [31:0] in_data;
  logic        in_last, in_valid, in_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic        busy, pkt_done;

  item_t sb[$];
  int    n_chk = 0, n_err = 0;
  int    hs_cnt = 0;
  int    sink_mode = 1;
  bit    in_pkt = 0;
  logic [7:0] mcsum = 8'h00;
  bit    prev_wait = 0, pd_pending = 0;
  logic [7:0] prev_data = 8'h00;

  uart_tx_packetizer #(.DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_count(fifo_count), .busy(busy), .pkt_done(pkt_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sink: 0 = never ready, 1 = always ready, 2 = one ready cycle per 868 (UART bit-time like).
  initial begin
    int cnt = 0;
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        default: begin
          tx_ready = (cnt == 867);
          cnt = (cnt == 867) ? 0 : cnt + 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      prev_wait  = 0;
      pd_pending = 0;
    end else begin
      check("pkt_done", pkt_done, pd_pending);
      if (prev_wait) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_data);
      end
      pd_pending = 0;
      if (tx_valid && tx_ready) begin
        hs_cnt++;
        if (sb.size() == 0) check("unexpected_byte", sb.size(), 1);
        else begin
          it = sb.pop_front();
          check("tx_byte", tx_data, it.b);
          pd_pending = it.fin;
        end
      end
      prev_wait = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  task automatic model_word(input logic [31:0] d, input logic l);
    logic [7:0] b;
    if (!in_pkt) begin
      sb.push_back(item_t'{SYNC, 1'b0});
      in_pkt = 1;
      mcsum  = 8'h00;
    end
    for (int k = 0; k < 4; k++) begin
      b = d[8*k +: 8];
      mcsum ^= b;
      sb.push_back(item_t'{b, l && (CS == 0) && (k == 3)});
    end
    if (l) begin
      if (CS == 1) sb.push_back(item_t'{mcsum, 1'b1});
      in_pkt = 0;
    end
  endtask

  // Called just after a posedge; returns just after the edge that sampled the word.
  task automatic send(input logic [31:0] d, input logic l, output bit acc);
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    acc = in_ready;
    if (acc) model_word(d, l);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
    check("busy_idle", busy, 0);
    check("idle_valid", tx_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    int base, n;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single word with latency check
    send(32'h11223344, 1'b1, acc);
    check("single_acc", acc, 1);
    @(negedge clk);
    check("lat_idle", tx_valid, 0);
    @(negedge clk);
    check("lat_sync_valid", tx_valid, 1);
    check("lat_sync_data", tx_data, SYNC);
    wait_drain(50);

    // Mid-packet starvation
    send(32'h000000FF, 1'b0, acc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 6) check("starve_valid", tx_valid, 0);
    end
    @(posedge clk); #1;
    send(32'h01020304, 1'b1, acc);
    wait_drain(50);

    // Back-to-back packets
    send(32'hAABBCCDD, 1'b1, acc);
    send(32'h00000001, 1'b1, acc);
    wait_drain(50);

    // Full FIFO: DEPTH+1 words with the sink stalled
    sink_mode = 0;
    base = hs_cnt;
    for (int i = 0; i <= DEPTH; i++) begin
      send(32'h5A000100 + i, (i == DEPTH - 1) || (i == DEPTH), acc);
      check("full_accept", acc, (i < DEPTH));
    end
    @(negedge clk);
    check("full_count", fifo_count, DEPTH);
    check("full_in_ready", in_ready, 0);
    check("full_busy", busy, 1);
    @(posedge clk); #1;
    sink_mode = 1;
    wait_drain(200);
    check("full_bytes", hs_cnt - base, 1 + 4 * DEPTH + CS);

    // Slow UART-like sink
    sink_mode = 2;
    send(32'hCAFEF00D, 1'b0, acc);
    send(32'h12345678, 1'b1, acc);
    wait_drain(12000);
    sink_mode = 1;

    // Reset after the second byte of a packet
    base = hs_cnt;
    send(32'h11223344, 1'b1, acc);
    n = 0;
    while (hs_cnt < base + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_bytes", hs_cnt - base, 2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    in_pkt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_fifo_count", fifo_count, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(32'h0BADF00D, 1'b1, acc);
    wait_drain(50);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
